// File: rtl/aftab_serial_subtractor.sv
// Digit-serial a - b - bin: one digit-bit slice per clock, LSB first, done N = size/digit cycles after accept.
// start is taken only while ready=1; results hold until the next completion or reset.
module aftab_serial_subtractor #(
  parameter int size  = 32,
  parameter int digit = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            bin,
  output logic            ready,
  output logic            done,
  output logic [size-1:0] diff,
  output logic            bout,
  output logic            ovf
);

  localparam int N  = size / digit;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [size-1:0]   a_sr;
  logic [size-1:0]   b_sr;
  logic [size-1:0]   res_sr;
  logic [size-1:0]   res_next;
  logic              borrow;
  logic              sa;
  logic              sb;
  logic [CW-1:0]     cnt;
  logic [digit:0]    sub;
  logic [digit-1:0]  slice;
  logic              borrow_next;

  // The slice for count k lands in digit position k, so after the last
  // slice res_next is the complete difference.
  always_comb begin
    sub         = {1'b0, a_sr[digit-1:0]} - {1'b0, b_sr[digit-1:0]} - {{digit{1'b0}}, borrow};
    slice       = sub[digit-1:0];
    borrow_next = sub[digit];
    res_next    = res_sr;
    res_next[int'(cnt)*digit +: digit] = slice;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            sa     <= a[size-1];
            sb     <= b[size-1];
            res_sr <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          a_sr   <= a_sr >> digit;
          b_sr   <= b_sr >> digit;
          res_sr <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            diff  <= res_next;
            bout  <= borrow_next;
            ovf   <= (sa != sb) && (res_next[size-1] != sa);
            done  <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_serial_subtractor.sv
// Scoreboard bench for aftab_serial_subtractor: arithmetic reference model, queue of
// expected results pushed on acceptance, negedge monitor popping on done.
module tb_aftab_serial_subtractor;
  localparam int SIZE  = 32;
  localparam int DIGIT = 8;
  localparam int N     = SIZE / DIGIT;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] b = '0;
  logic            bin = 1'b0;
  logic            ready;
  logic            done;
  logic [SIZE-1:0] diff;
  logic            bout;
  logic            ovf;

  aftab_serial_subtractor #(.size(SIZE), .digit(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] diff;
    logic            bout;
    logic            ovf;
    int              cyc;
  } exp_t;

  exp_t            q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic            rdy_m = 1'b1;
  logic            done_m = 1'b0;
  int              rem = 0;
  logic [SIZE-1:0] h_diff = '0;
  logic            h_bout = 1'b0;
  logic            h_ovf = 1'b0;

  function automatic exp_t model(input logic [SIZE-1:0] ma, input logic [SIZE-1:0] mb,
                                 input logic mbin, input int mcyc);
    exp_t        e;
    logic [SIZE:0] full;
    longint      sa;
    longint      sb;
    longint      sd;
    full   = {1'b0, ma} - {1'b0, mb} - (SIZE+1)'(mbin);
    sa     = $signed(ma);
    sb     = $signed(mb);
    sd     = sa - sb - longint'(mbin);
    e.diff = full[SIZE-1:0];
    e.bout = full[SIZE];
    e.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.cyc  = mcyc;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model of acceptance, busy time and reset.
  always @(posedge clk) begin
    cyc++;
    done_m = 1'b0;
    if (!rst) begin
      rdy_m  = 1'b1;
      rem    = 0;
      q.delete();
      h_diff = '0;
      h_bout = 1'b0;
      h_ovf  = 1'b0;
    end else if (rdy_m) begin
      if (start) begin
        q.push_back(model(a, b, bin, cyc));
        rdy_m = 1'b0;
        rem   = N;
      end
    end else begin
      rem--;
      if (rem == 0) begin
        rdy_m  = 1'b1;
        done_m = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      check("ready", 64'(ready), 64'(rdy_m));
      check("done", 64'(done), 64'(done_m));
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("diff", 64'(diff), 64'(e.diff));
          check("bout", 64'(bout), 64'(e.bout));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("latency", 64'(cyc - e.cyc), 64'(N));
          h_diff = e.diff;
          h_bout = e.bout;
          h_ovf  = e.ovf;
        end
      end else begin
        check("hold_diff", 64'(diff), 64'(h_diff));
        check("hold_bout", 64'(bout), 64'(h_bout));
        check("hold_ovf", 64'(ovf), 64'(h_ovf));
      end
    end
  end

  task automatic issue(input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib, input logic ibin);
    int w;
    w = 0;
    while (!rdy_m && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!rdy_m) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    start = 1'b1;
    a     = ia;
    b     = ib;
    bin   = ibin;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    bin   = 1'($urandom);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    issue(32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(32'h0000_0100, 32'h0000_0000, 1'b1);
    issue($urandom, 32'hFFFF_FFFF, 1'b1);
    issue(32'h0000_000A, 32'h0000_0004, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // start held high with operands churning every cycle
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a   = $urandom;
      b   = $urandom;
      bin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;

    // reset at the second edge after acceptance
    issue(32'h1234_5678, 32'h0000_1111, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      logic [SIZE-1:0] ra;
      logic [SIZE-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra + 32'($urandom_range(0, 2)) - 32'd1;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      issue(ra, rb, 1'($urandom));
    end

    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aftab_serial_subtractor.md
Name: aftab_serial_subtractor

Overview:
- Multi-cycle, digit-serial subtractor for the AFTAB datapath. Computes diff = a - b - bin over `size` bits.
- Processes one `digit`-bit slice per clock, LSB slice first, with a ripple borrow between slices.
- Intended for area-constrained configurations and the iterative divide path, where a full-width combinational subtract is not affordable.
- Uses a start/ready/done handshake.

Parameters:
- size, 32, operand and result width in bits. Must be an integer multiple of digit.
- digit, 8, bits processed per cycle. N = size/digit cycles per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request a new operation. Sampled only while ready=1.
- a  input  size  minuend. Sampled on the accepting edge.
- b  input  size  subtrahend. Sampled on the accepting edge.
- bin  input  1  borrow-in. Sampled on the accepting edge.
- ready  output  1  high when a start will be accepted.
- done  output  1  one-cycle pulse; result outputs are valid in this cycle.
- diff  output  size  result a - b - bin, modulo 2^size.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin (unsigned).
- ovf  output  1  two's-complement overflow of a - b - bin.

Behaviour:
- Reset (rst=0 at a rising edge), applied regardless of state, including mid-operation:
  - state=IDLE, ready=1, done=0, diff=0, bout=0, ovf=0.
  - Internal operand shift registers, borrow register and slice counter are cleared.
  - Any in-flight operation is discarded with no done pulse.
- States: IDLE and BUSY.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch a, b, bin; borrow<=bin; cnt<=0; store a[size-1] and b[size-1] for ovf; go to BUSY; ready<=0.
- BUSY:
  - ready=0. start is ignored and operands may change freely.
  - Each edge: {borrow_next, slice} = a_lo - b_lo - borrow, where a_lo and b_lo are the low digit bits of the operand shift registers.
  - Operand registers shift right by digit. slice shifts into the top of the result shift register. borrow<=borrow_next. cnt<=cnt+1.
- Completion, on the edge where cnt = N-1:
  - diff<=final result register contents.
  - bout<=borrow_next.
  - ovf<=(sa != sb) && (diff[size-1] != sa).
  - done<=1, ready<=1, state<=IDLE.
- Latency: start accepted at edge E0, slices processed at edges E1..EN, done=1 in the cycle following edge EN, i.e. N clock cycles after acceptance.
- done is high for exactly one cycle. It deasserts at the next edge unless that edge completes another operation.
- diff, bout and ovf are updated only at completion. They hold their values until the next completion or reset, and never show partial results.
- Back-to-back: start=1 during the done cycle (ready=1) is accepted. The next done follows exactly N cycles later, giving throughput of one result per N cycles.
- Boundary cases:
  - N=1 (digit=size) is legal: done follows start by one cycle.
  - Wrap-around is modulo 2^size. 0 - 1 gives all ones with bout=1.
  - bin=1 with b = all ones gives bout=1 for any a.

Test Plan (size=32, digit=8, N=4):
- a=0x00000005, b=0x00000003, bin=0, start pulse → ready drops next cycle; done=1 exactly 4 cycles after the accepting edge with diff=0x00000002, bout=0, ovf=0.
- a=0x00000000, b=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0.
- a=0x80000000, b=0x00000001, bin=0 → diff=0x7FFFFFFF, bout=0, ovf=1. Also a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, bout=1, ovf=1.
- a=0x00000100, b=0x00000000, bin=1 (borrow crosses a digit boundary) → diff=0x000000FF, bout=0, ovf=0.
- Start held high and operands changed every cycle while BUSY → the result matches the operands latched at acceptance; only one done per acceptance.
- Mid-operation reset: rst=0 at edge E2 → next cycle ready=1, done=0, diff=0, bout=0, ovf=0, and no done pulse follows.
- Back-to-back: second start with a=10, b=4 asserted during the first done cycle → second done 4 cycles later with diff=6; the first result holds until then.
